// File: rtl/key_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : key_sequencer_if
// Purpose  : Handshake/data bundle between a key-code requester and the
//            key_sequencer keypad driver.
// Signals  : Start     - request to play Code_IN (requester -> sequencer)
//            Abort     - cancel the sequence in progress
//            Code_IN   - four 2-bit key indices, digit0 in [1:0]
//            Key_OUT   - one-hot keypad drive or 4'b0000
//            Busy      - sequence in progress
//            Done      - one-cycle completion pulse
//            Digit_IDX - digit currently being played, 0 when idle
// Revision : 1.0 - initial release
// ============================================================================
interface key_sequencer_if;
  logic       Start;
  logic       Abort;
  logic [7:0] Code_IN;
  logic [3:0] Key_OUT;
  logic       Busy;
  logic       Done;
  logic [1:0] Digit_IDX;

  // Requester side
  modport master (
    output Start, Abort, Code_IN,
    input  Key_OUT, Busy, Done, Digit_IDX
  );

  // Sequencer side
  modport slave (
    input  Start, Abort, Code_IN,
    output Key_OUT, Busy, Done, Digit_IDX
  );
endinterface
`default_nettype wire

// File: rtl/key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : key_sequencer
// Purpose  : Plays a latched 4-digit key code onto a one-hot keypad drive.
//            Each key is held for HOLD_CYC cycles followed by GAP_CYC idle
//            cycles, then a one-cycle FINISH state pulses Done.
// Ports    : Seq_CLK  - clock, rising edge
//            Seq_RSTn - asynchronous active-low reset
//            bus      - key_sequencer_if.slave (Start, Abort, Code_IN in;
//                       Key_OUT, Busy, Done, Digit_IDX out)
// Params   : HOLD_CYC - key hold time in cycles (1..255)
//            GAP_CYC  - zero interval after each key in cycles (1..255)
// Revision : 1.0 - initial release
// ============================================================================
module key_sequencer #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic            Seq_CLK,
  input  logic            Seq_RSTn,
  key_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // Counters run down to zero, so a phase of N cycles loads N-1.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYC - 1);

  logic [1:0] state;
  logic [7:0] cyc_cnt;
  logic [1:0] digit;
  logic [7:0] code_q;
  logic [3:0] key_q;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  function automatic logic [1:0] digit_of(input logic [7:0] code, input logic [1:0] idx);
    case (idx)
      2'd0:    digit_of = code[1:0];
      2'd1:    digit_of = code[3:2];
      2'd2:    digit_of = code[5:4];
      default: digit_of = code[7:6];
    endcase
  endfunction

  always_ff @(posedge Seq_CLK or negedge Seq_RSTn) begin
    if (!Seq_RSTn) begin
      state   <= IDLE;
      cyc_cnt <= 8'd0;
      digit   <= 2'd0;
      code_q  <= 8'd0;
      key_q   <= 4'b0000;
    end else if (bus.Abort) begin
      // Abort wins everywhere: in IDLE it also suppresses a same-cycle Start.
      state   <= IDLE;
      cyc_cnt <= 8'd0;
      digit   <= 2'd0;
      key_q   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            code_q  <= bus.Code_IN;
            digit   <= 2'd0;
            cyc_cnt <= HOLD_LOAD;
            // Key is registered on the same edge that enters HOLD so the
            // first press is visible immediately after the Start edge.
            key_q   <= onehot(bus.Code_IN[1:0]);
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (cyc_cnt == 8'd0) begin
            state   <= GAP;
            cyc_cnt <= GAP_LOAD;
            key_q   <= 4'b0000;
          end else begin
            cyc_cnt <= cyc_cnt - 8'd1;
          end
        end
        GAP: begin
          if (cyc_cnt == 8'd0) begin
            if (digit == 2'd3) begin
              state <= FINISH;
            end else begin
              digit   <= digit + 2'd1;
              cyc_cnt <= HOLD_LOAD;
              key_q   <= onehot(digit_of(code_q, digit + 2'd1));
              state   <= HOLD;
            end
          end else begin
            cyc_cnt <= cyc_cnt - 8'd1;
          end
        end
        FINISH: begin
          state   <= IDLE;
          digit   <= 2'd0;
          cyc_cnt <= 8'd0;
          key_q   <= 4'b0000;
        end
        default: begin
          state   <= IDLE;
          digit   <= 2'd0;
          cyc_cnt <= 8'd0;
          key_q   <= 4'b0000;
        end
      endcase
    end
  end

  // Busy/Done decode straight from the state register, so they clear
  // together with the state on an asynchronous reset.
  assign bus.Key_OUT   = key_q;
  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = (state == FINISH);
  assign bus.Digit_IDX = digit;

endmodule
`default_nettype wire

// File: tb/tb_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_sequencer
// Purpose  : Directed self-checking bench for key_sequencer. Two instances:
//            u_dut0 with default timing (4/2) driving a 2-8-1-4 lock model,
//            u_dut1 with HOLD_CYC=1, GAP_CYC=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  bit   sel;

  key_sequencer_if if0 ();
  key_sequencer_if if1 ();

  key_sequencer u_dut0 (
    .Seq_CLK  (clk),
    .Seq_RSTn (rst_n),
    .bus      (if0.slave)
  );

  key_sequencer #(.HOLD_CYC(1), .GAP_CYC(1)) u_dut1 (
    .Seq_CLK  (clk),
    .Seq_RSTn (rst_n),
    .bus      (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] obs_key;
  logic       obs_busy;
  logic       obs_done;
  logic [1:0] obs_idx;
  assign obs_key  = sel ? if1.Key_OUT   : if0.Key_OUT;
  assign obs_busy = sel ? if1.Busy      : if0.Busy;
  assign obs_done = sel ? if1.Done      : if0.Done;
  assign obs_idx  = sel ? if1.Digit_IDX : if0.Digit_IDX;

  // Combination lock 2-8-1-4 on the default instance: a fresh press that
  // matches the next expected key advances; any other press resets.
  logic [3:0] lock_code [4];
  logic [2:0] lock_stage;
  logic [3:0] lock_prev;
  initial lock_code = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_stage <= 3'd0;
      lock_prev  <= 4'b0000;
    end else begin
      lock_prev <= if0.Key_OUT;
      if (if0.Key_OUT != 4'b0000 && lock_prev == 4'b0000) begin
        if (lock_stage < 3'd4 && if0.Key_OUT == lock_code[lock_stage[1:0]])
          lock_stage <= lock_stage + 3'd1;
        else
          lock_stage <= 3'd0;
      end
    end
  end

  function automatic logic [3:0] lock_led(input logic [2:0] st);
    case (st)
      3'd0:    lock_led = 4'd0;
      3'd1:    lock_led = 4'd1;
      3'd2:    lock_led = 4'd3;
      3'd3:    lock_led = 4'd7;
      default: lock_led = 4'd15;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit s, input logic st, input logic ab, input logic [7:0] cd);
    if (s) begin
      if1.Start = st; if1.Abort = ab; if1.Code_IN = cd;
    end else begin
      if0.Start = st; if0.Abort = ab; if0.Code_IN = cd;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_key"},  32'(obs_key),  32'h0);
    check_eq({tag, "_busy"}, 32'(obs_busy), 32'h0);
    check_eq({tag, "_done"}, 32'(obs_done), 32'h0);
    check_eq({tag, "_idx"},  32'(obs_idx),  32'h0);
  endtask

  // Called at a negedge with the selected DUT idle. Pulses Start with code,
  // then checks every cycle against the hand-given key list k0..k3.
  // restart_at: cycle at which Start is re-pulsed with a different code.
  // abort_at  : cycle after which Abort is raised (ends the run early).
  task automatic run_seq(input bit s, input logic [7:0] code,
                         input logic [3:0] k0, input logic [3:0] k1,
                         input logic [3:0] k2, input logic [3:0] k3,
                         input int hold, input int gap,
                         input int restart_at, input int abort_at, input string tag);
    logic [3:0] keys [4];
    logic [3:0] exp_key;
    int total;
    int d;
    keys  = '{k0, k1, k2, k3};
    total = 4 * (hold + gap);
    sel   = s;
    drive(s, 1'b1, 1'b0, code);
    @(negedge clk);
    // Code_IN is scrambled from here on; the latched copy must be used.
    drive(s, 1'b0, 1'b0, ~code);
    for (int c = 0; c < total; c++) begin
      d       = c / (hold + gap);
      exp_key = ((c % (hold + gap)) < hold) ? keys[d] : 4'b0000;
      check_eq($sformatf("%s_c%0d_key", tag, c),  32'(obs_key),  32'(exp_key));
      check_eq($sformatf("%s_c%0d_busy", tag, c), 32'(obs_busy), 32'h1);
      check_eq($sformatf("%s_c%0d_done", tag, c), 32'(obs_done), 32'h0);
      check_eq($sformatf("%s_c%0d_idx", tag, c),  32'(obs_idx),  32'(d));
      if (c == restart_at)
        drive(s, 1'b1, 1'b0, 8'b01_11_00_10);
      else
        drive(s, 1'b0, 1'b0, ~code);
      if (c == abort_at) begin
        drive(s, 1'b0, 1'b1, ~code);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, ~code);
        check_idle({tag, "_abort"});
        @(negedge clk);
        check_idle({tag, "_abort2"});
        return;
      end
      @(negedge clk);
    end
    check_eq({tag, "_fin_done"}, 32'(obs_done), 32'h1);
    check_eq({tag, "_fin_busy"}, 32'(obs_busy), 32'h1);
    check_eq({tag, "_fin_key"},  32'(obs_key),  32'h0);
    @(negedge clk);
    check_idle({tag, "_post"});
    @(negedge clk);
    check_idle({tag, "_post2"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 1'b0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    sel = 1'b0; check_idle("rst0");
    sel = 1'b1; check_idle("rst1");
    rst_n = 1'b1;
    @(negedge clk);
    sel = 1'b0; check_idle("rel0");

    // Default timing, code 2-8-1-4 opens the lock
    run_seq(1'b0, 8'b10_00_11_01, 4'b0010, 4'b1000, 4'b0001, 4'b0100,
            4, 2, -1, -1, "seq_a");
    check_eq("lock_open", 32'(lock_led(lock_stage)), 32'd15);

    // Repeated digit 8,8 with the zero gap between; lock falls back
    run_seq(1'b0, 8'b10_00_11_11, 4'b1000, 4'b1000, 4'b0001, 4'b0100,
            4, 2, -1, -1, "seq_b");
    check_eq("lock_reset", 32'(lock_led(lock_stage)), 32'd0);

    // Start re-pulsed in HOLD of digit 1 (cycle 7) is ignored
    run_seq(1'b0, 8'b10_00_11_01, 4'b0010, 4'b1000, 4'b0001, 4'b0100,
            4, 2, 7, -1, "restart");

    // Abort in GAP of digit 2 (cycle 16), then full replay from digit 0
    run_seq(1'b0, 8'b10_00_11_01, 4'b0010, 4'b1000, 4'b0001, 4'b0100,
            4, 2, -1, 16, "abort");
    run_seq(1'b0, 8'b10_00_11_01, 4'b0010, 4'b1000, 4'b0001, 4'b0100,
            4, 2, -1, -1, "replay");

    // Start and Abort together in IDLE: Abort wins
    sel = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 8'h1B);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h1B);
    check_idle("st_ab");
    @(negedge clk);
    check_idle("st_ab2");

    // Asynchronous reset during HOLD clears outputs before any clock edge
    drive(1'b0, 1'b1, 1'b0, 8'b10_00_11_01);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("pre_rst_key", 32'(obs_key), 32'h2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_rst");
    @(negedge clk);
    check_idle("after_rst2");

    // Fast timing: 0001/0000 alternating four times, Done at Start+9
    run_seq(1'b1, 8'h00, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
            1, 1, -1, -1, "fast");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
